inert_rd_seq: RTL and testbench
===============================

Name: inert_rd_seq

Overview:
- Parametrised successor to the fixed-function inertial SPI sequencer.
- Powers up and configures an inertial sensor through an external 16-bit SPI master using a parameterised init-command list.
- On each sensor data-ready edge, burst-reads NUM_CH 16-bit channels (low byte then high byte, auto-incrementing address) and presents them atomically with a vld pulse.
- Adds timeout recovery with re-init, and overrun detection for queued/dropped samples.

Parameters:
- NUM_CH, 5, number of 16-bit channels read per sample (1..8).
- BASE_ADDR, 7'h22, register address of channel 0 low byte.
- NUM_INIT, 4, number of init commands (1..8).
- INIT_CMDS, {16'h1460,16'h1162,16'h1062,16'h0D02}, packed NUM_INIT*16 bits; entry 0 in bits [15:0], sent first.
- PWRUP_W, 16, power-up wait is 2^PWRUP_W-1 cycles.
- TMO_CYC, 1024, maximum cycles to wait for spi_done.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- INT  in  1  sensor data-ready, asynchronous
- spi_done  in  1  SPI master transaction complete, 1-cycle pulse
- spi_rd  in  16  SPI read data; byte used is [7:0]
- spi_wrt  out  1  start SPI transaction, 1-cycle pulse
- spi_cmd  out  16  SPI command word, valid while spi_wrt=1
- data  out  NUM_CH*16  channel k at [16k+15:16k]
- vld  out  1  1-cycle pulse, data updated this cycle
- init_done  out  1  high once init sequence completes
- ovr  out  1  1-cycle pulse, sample dropped
- tmo  out  1  sticky, a done-timeout occurred

Behaviour:
- Reset values: data=0, vld=0, init_done=0, ovr=0, tmo=0, spi_wrt=0, spi_cmd=0. State=PWRUP, all counters=0, pending=0.
- Reset asserted mid-transaction aborts immediately. The SPI master is reset by the same rst.
- INT path: double-flopped to INT_s, then one more flop. An edge is INT_s & ~INT_s_d; edges are counted, not levels.
- PWRUP:
  - Counter increments each cycle.
  - When all ones: spi_wrt=1, spi_cmd=INIT_CMDS entry 0, idx=0, go to INIT_WAIT.
- INIT_WAIT:
  - On spi_done with idx<NUM_INIT-1: idx++, spi_wrt=1 with the next entry in the same cycle.
  - On spi_done with idx=NUM_INIT-1: init_done=1 next cycle, go to IDLE.
- IDLE:
  - On edge or pending=1: pending=0, byte=0, spi_wrt=1, spi_cmd={1'b1, BASE_ADDR, 8'h00}, go to RD_WAIT.
  - Edges arriving before init_done are ignored.
- RD_WAIT:
  - On spi_done: spi_rd[7:0] goes to shadow byte `byte`. Even byte = low half, odd byte = high half of channel byte>>1.
  - If byte<2*NUM_CH-1: byte++, spi_wrt=1 in the same cycle, cmd={1'b1, BASE_ADDR+byte+1, 8'h00}. Address is 7-bit and wraps modulo 128.
  - If last byte: go to PUBLISH.
- PUBLISH (1 cycle):
  - data<=shadow (last byte merged), vld=1, go to IDLE.
  - If pending=1, IDLE restarts the read the following cycle.
  - Latency from last spi_done to vld = 1 cycle.
- Overrun:
  - An edge while in RD_WAIT/PUBLISH with pending=0 sets pending.
  - An edge with pending=1 pulses ovr for 1 cycle; pending stays 1 (max one queued sample).
  - An edge coincident with IDLE start is consumed by that start, not queued.
- Timeout:
  - Wait counter clears on every spi_wrt and increments in INIT_WAIT/RD_WAIT.
  - Reaching TMO_CYC without spi_done: tmo<=1 (sticky until rst), init_done<=0, pending<=0, state<=PWRUP with counter cleared. Partial shadow is discarded and data holds its last published value.
- spi_wrt is never asserted while a transaction is outstanding. spi_done outside INIT_WAIT/RD_WAIT is ignored.
- spi_cmd holds its last value when spi_wrt=0.

Test Plan:
- Power-up (PWRUP_W=4, defaults): after 15 cycles, spi_cmd sequence is 0D02, 1062, 1162, 1460, each issued on the prior spi_done. init_done rises 1 cycle after the 4th done.
- Single sample, NUM_CH=5: one INT edge gives 10 reads, cmds A200..AB00. Model returns byte = address, so data[15:0]=16'h2322 … data[79:64]=16'h2B2A. vld is exactly 1 pulse, 1 cycle after the 10th done.
- NUM_CH=2, BASE_ADDR=7'h7F: commands are FF00, 8000, 8100, 8200 (address wrap). data updates only at vld; no partial values are visible mid-burst.
- Overrun: 3 INT edges during one burst give 1 ovr pulse (on the 3rd edge), a second burst starting 1 cycle after the first vld, and 2 vld total.
- Timeout (TMO_CYC=16): suppress spi_done on the 3rd read. tmo rises at cycle 16 after that spi_wrt, init_done falls, and the init sequence replays. data keeps its previous sample.
- Async rst mid-burst: all outputs return to reset values immediately, then the full power-up sequence repeats.

Source files
------------

// File: rtl/inert_rd_seq.sv
// Inertial sensor sequencer: powers up and configures the sensor through a 16-bit SPI master,
// then burst-reads NUM_CH channels per data-ready edge, with timeout re-init and overrun flagging.
//
// state       | meaning
// PWRUP       | power-up wait, then issue init command 0
// INIT_WAIT   | waiting for done of init command idx
// IDLE        | initialised, waiting for a data-ready edge or queued sample
// RD_WAIT     | waiting for done of read byte `byte`
// PUBLISH     | vld cycle for the freshly published sample
module inert_rd_seq #(
    parameter int                     NUM_CH    = 5,
    parameter logic [6:0]             BASE_ADDR = 7'h22,
    parameter int                     NUM_INIT  = 4,
    parameter logic [NUM_INIT*16-1:0] INIT_CMDS = {16'h1460, 16'h1162, 16'h1062, 16'h0D02},
    parameter int                     PWRUP_W   = 16,
    parameter int                     TMO_CYC   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 INT,
    input  logic                 spi_done,
    input  logic [15:0]          spi_rd,
    output logic                 spi_wrt,
    output logic [15:0]          spi_cmd,
    output logic [NUM_CH*16-1:0] data,
    output logic                 vld,
    output logic                 init_done,
    output logic                 ovr,
    output logic                 tmo
);

    localparam int                WW        = $clog2(TMO_CYC + 1);
    localparam logic [3:0]        LAST_BYTE = 4'(2 * NUM_CH - 1);
    localparam logic [2:0]        LAST_IDX  = 3'(NUM_INIT - 1);
    localparam logic [WW-1:0]     TMO_LAST  = WW'(TMO_CYC - 1);
    localparam logic [WW-1:0]     WW_ONE    = 1;
    localparam logic [PWRUP_W-1:0] PW_ONE   = 1;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT_WAIT,
        S_IDLE,
        S_RD_WAIT,
        S_PUBLISH
    } state_t;

    state_t                 state_q;
    logic [PWRUP_W-1:0]     pwr_cnt_q;
    logic [WW-1:0]          wait_q;
    logic [2:0]             idx_q;
    logic [3:0]             byte_q;
    logic                   pending_q;
    logic                   int_m_q, int_s_q, int_s_d_q;
    logic [NUM_CH*16-1:0]   shadow_q, shadow_d;
    logic [NUM_CH*16-1:0]   data_q;
    logic                   vld_q, init_done_q, ovr_q, tmo_q, spi_wrt_q;
    logic [15:0]            spi_cmd_q;

    logic                   int_edge;
    logic                   tmo_hit;
    logic [2:0]             idx_nxt;
    logic [6:0]             addr_d;
    logic [15:0]            init_tbl [8];
    logic                   unused_rd_hi;

    // Pad the command table to 8 entries so idx never selects outside it.
    for (genvar g = 0; g < 8; g++) begin : g_init
        if (g < NUM_INIT) begin : g_use
            assign init_tbl[g] = INIT_CMDS[16*g +: 16];
        end else begin : g_pad
            assign init_tbl[g] = 16'h0000;
        end
    end

    assign int_edge     = int_s_q & ~int_s_d_q;
    assign idx_nxt      = idx_q + 3'd1;
    assign addr_d       = BASE_ADDR + {3'b000, byte_q} + 7'd1;
    assign unused_rd_hi = ^spi_rd[15:8];
    assign tmo_hit      = (state_q == S_INIT_WAIT || state_q == S_RD_WAIT)
                          && !spi_done && (wait_q == TMO_LAST);

    // Shadow with the incoming byte merged, so the last byte can publish in the same edge.
    always_comb begin
        shadow_d = shadow_q;
        shadow_d[int'(byte_q) * 8 +: 8] = spi_rd[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PWRUP;
            pwr_cnt_q   <= '0;
            wait_q      <= '0;
            idx_q       <= '0;
            byte_q      <= '0;
            pending_q   <= 1'b0;
            int_m_q     <= 1'b0;
            int_s_q     <= 1'b0;
            int_s_d_q   <= 1'b0;
            shadow_q    <= '0;
            data_q      <= '0;
            vld_q       <= 1'b0;
            init_done_q <= 1'b0;
            ovr_q       <= 1'b0;
            tmo_q       <= 1'b0;
            spi_wrt_q   <= 1'b0;
            spi_cmd_q   <= '0;
        end else begin
            int_m_q   <= INT;
            int_s_q   <= int_m_q;
            int_s_d_q <= int_s_q;
            spi_wrt_q <= 1'b0;
            vld_q     <= 1'b0;
            ovr_q     <= 1'b0;

            // At most one sample can be queued behind the burst in flight.
            if (int_edge && (state_q == S_RD_WAIT || state_q == S_PUBLISH)) begin
                if (pending_q) ovr_q <= 1'b1;
                else           pending_q <= 1'b1;
            end

            case (state_q)
                S_PWRUP: begin
                    pwr_cnt_q <= pwr_cnt_q + PW_ONE;
                    if (&pwr_cnt_q) begin
                        spi_wrt_q <= 1'b1;
                        spi_cmd_q <= init_tbl[0];
                        idx_q     <= '0;
                        wait_q    <= '0;
                        state_q   <= S_INIT_WAIT;
                    end
                end
                S_INIT_WAIT: begin
                    if (spi_done) begin
                        if (idx_q == LAST_IDX) begin
                            init_done_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            idx_q     <= idx_nxt;
                            spi_wrt_q <= 1'b1;
                            spi_cmd_q <= init_tbl[idx_nxt];
                            wait_q    <= '0;
                        end
                    end else begin
                        wait_q <= wait_q + WW_ONE;
                    end
                end
                S_IDLE: begin
                    if (int_edge || pending_q) begin
                        pending_q <= 1'b0;
                        byte_q    <= '0;
                        spi_wrt_q <= 1'b1;
                        spi_cmd_q <= {1'b1, BASE_ADDR, 8'h00};
                        wait_q    <= '0;
                        state_q   <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (spi_done) begin
                        shadow_q <= shadow_d;
                        if (byte_q == LAST_BYTE) begin
                            data_q  <= shadow_d;
                            vld_q   <= 1'b1;
                            state_q <= S_PUBLISH;
                        end else begin
                            byte_q    <= byte_q + 4'd1;
                            spi_wrt_q <= 1'b1;
                            spi_cmd_q <= {1'b1, addr_d, 8'h00};
                            wait_q    <= '0;
                        end
                    end else begin
                        wait_q <= wait_q + WW_ONE;
                    end
                end
                S_PUBLISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_PWRUP;
                end
            endcase

            // Lost handshake: drop the partial burst and configure the sensor again.
            if (tmo_hit) begin
                tmo_q       <= 1'b1;
                init_done_q <= 1'b0;
                pending_q   <= 1'b0;
                pwr_cnt_q   <= '0;
                state_q     <= S_PWRUP;
            end
        end
    end

    assign spi_wrt   = spi_wrt_q;
    assign spi_cmd   = spi_cmd_q;
    assign data      = data_q;
    assign vld       = vld_q;
    assign init_done = init_done_q;
    assign ovr       = ovr_q;
    assign tmo       = tmo_q;

endmodule

// File: tb/tb_inert_rd_seq.sv
// Directed bench for inert_rd_seq: a 5-channel instance and a 2-channel address-wrap instance,
// each served by a small SPI master model that answers with byte = register address.
module tb_inert_rd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        int0 = 1'b0, int1 = 1'b0;
    logic        done0 = 1'b0, done1 = 1'b0;
    logic [15:0] rd0 = '0, rd1 = '0;
    logic        wrt0, wrt1;
    logic [15:0] cmd0, cmd1;
    logic [79:0] data0;
    logic [31:0] data1;
    logic        vld0, vld1, idn0, idn1, ovr0, ovr1, tmo0, tmo1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int busy [2] = '{0, 0};
    int lat  [2] = '{0, 0};
    int rdcnt[2] = '{0, 0};
    int done_cyc[2] = '{0, 0};
    logic [6:0] addr[2] = '{7'h00, 7'h00};
    int drop_at = 0;
    int drop_wrt_cyc = 0;
    int vld_cnt0 = 0, vld_cnt1 = 0, ovr_cnt0 = 0;
    int last_vld0 = 0, gap0 = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] exp_init[4] = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};

    inert_rd_seq #(.NUM_CH(5), .BASE_ADDR(7'h22), .PWRUP_W(4), .TMO_CYC(16)) u_dut0 (
        .clk(clk), .rst(rst), .INT(int0), .spi_done(done0), .spi_rd(rd0),
        .spi_wrt(wrt0), .spi_cmd(cmd0), .data(data0), .vld(vld0),
        .init_done(idn0), .ovr(ovr0), .tmo(tmo0)
    );

    inert_rd_seq #(.NUM_CH(2), .BASE_ADDR(7'h7F), .PWRUP_W(4), .TMO_CYC(16)) u_dut1 (
        .clk(clk), .rst(rst), .INT(int1), .spi_done(done1), .spi_rd(rd1),
        .spi_wrt(wrt1), .spi_cmd(cmd1), .data(data1), .vld(vld1),
        .init_done(idn1), .ovr(ovr1), .tmo(tmo1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // SPI master model: done 4 (inst0) or 7 (inst1) cycles after the request.
    task automatic resp(input int i, input logic wrt, input logic [15:0] cmd,
                        output logic done, output logic [15:0] rd);
        done = 1'b0;
        if (rst) begin
            busy[i] = 0;
        end else begin
            if (busy[i] != 0) begin
                if (lat[i] == 0) begin
                    done = 1'b1;
                    busy[i] = 0;
                    done_cyc[i] = cyc;
                end else begin
                    lat[i]--;
                end
            end
            if (wrt) begin
                chk($sformatf("no_overlap%0d", i), 80'(busy[i]), 80'd0);
                if (i == 0) q0.push_back(cmd);
                else        q1.push_back(cmd);
                addr[i] = cmd[14:8];
                lat[i]  = (i == 0) ? 3 : 6;
                busy[i] = 1;
                if (cmd[15]) begin
                    rdcnt[i]++;
                    if (i == 0 && rdcnt[0] == drop_at) begin
                        busy[0] = 0;
                        drop_wrt_cyc = cyc;
                    end
                end
            end
        end
        rd = {8'h5A, 1'b0, addr[i]};
    endtask

    always @(negedge clk) begin
        resp(0, wrt0, cmd0, done0, rd0);
        resp(1, wrt1, cmd1, done1, rd1);
        if (vld0) begin
            vld_cnt0++;
            last_vld0 = cyc;
        end
        if (vld1) vld_cnt1++;
        if (ovr0) ovr_cnt0++;
        if (wrt0 && cmd0 == 16'hA200) gap0 = cyc - last_vld0;
    end

    task automatic pulse_int0(input int hi, input int lo);
        int0 = 1'b1;
        repeat (hi) @(negedge clk);
        int0 = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        int n;
        int t0;
        int r0;
        logic [79:0] sample;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_data", data0, 80'd0);
        chk("rst_vld", vld0, 1'b0);
        chk("rst_init_done", idn0, 1'b0);
        chk("rst_tmo", tmo0, 1'b0);
        chk("rst_ovr", ovr0, 1'b0);
        chk("rst_spi_wrt", wrt0, 1'b0);
        chk("rst_spi_cmd", cmd0, 16'h0000);

        // power-up and init sequence
        rst = 1'b0;
        t0 = cyc;
        n = 0;
        while (!wrt0 && n < 100) begin @(negedge clk); n++; end
        chk("pwrup_cycles", 80'(cyc - t0), 80'd16);
        chk("pwrup_cmd0", cmd0, 16'h0D02);
        pulse_int0(3, 1);
        n = 0;
        while (!idn0 && n < 200) begin @(negedge clk); n++; end
        chk("init_done_rise", idn0, 1'b1);
        chk("init_done_lat", 80'(cyc - done_cyc[0]), 80'd1);
        chk("init_cmd_count", 80'(q0.size()), 80'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("init_cmd%0d", k), (k < q0.size()) ? q0[k] : 16'hxxxx, exp_init[k]);
        repeat (10) @(negedge clk);
        chk("early_int_ignored", 80'(rdcnt[0]), 80'd0);

        // single sample, 5 channels
        q0.delete();
        vld_cnt0 = 0;
        pulse_int0(4, 0);
        n = 0;
        while (!vld0 && n < 200) begin @(negedge clk); n++; end
        chk("vld_seen", vld0, 1'b1);
        chk("vld_lat", 80'(cyc - done_cyc[0]), 80'd1);
        chk("sample_data", data0, 80'h2B2A_2928_2726_2524_2322);
        repeat (20) @(negedge clk);
        chk("vld_pulses", 80'(vld_cnt0), 80'd1);
        chk("rd_cmd_count", 80'(q0.size()), 80'd10);
        for (int k = 0; k < 10; k++)
            chk($sformatf("rd_cmd%0d", k), (k < q0.size()) ? q0[k] : 16'hxxxx,
                16'hA200 + 16'(k) * 16'h0100);
        sample = data0;

        // overrun: three edges during one burst
        q0.delete();
        vld_cnt0 = 0;
        ovr_cnt0 = 0;
        pulse_int0(3, 5);
        pulse_int0(3, 5);
        pulse_int0(3, 5);
        n = 0;
        while (vld_cnt0 < 2 && n < 300) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        chk("ovr_pulses", 80'(ovr_cnt0), 80'd1);
        chk("ovr_vld_pulses", 80'(vld_cnt0), 80'd2);
        chk("ovr_rd_count", 80'(q0.size()), 80'd20);
        chk("ovr_restart_gap_ok", (gap0 >= 1 && gap0 <= 2), 1'b1);
        chk("ovr_data", data0, sample);

        // 2-channel instance: address wrap, no partial data
        n = 0;
        while (!idn1 && n < 200) begin @(negedge clk); n++; end
        chk("inst1_init_done", idn1, 1'b1);
        q1.delete();
        int1 = 1'b1;
        repeat (3) @(negedge clk);
        int1 = 1'b0;
        n = 0;
        while (rdcnt[1] < 2 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("inst1_no_partial", data1, 32'h0);
        n = 0;
        while (!vld1 && n < 200) begin @(negedge clk); n++; end
        chk("inst1_data", data1, 32'h0201_007F);
        chk("inst1_cmd_count", 80'(q1.size()), 80'd4);
        chk("inst1_cmd0", (q1.size() > 0) ? q1[0] : 16'hxxxx, 16'hFF00);
        chk("inst1_cmd1", (q1.size() > 1) ? q1[1] : 16'hxxxx, 16'h8000);
        chk("inst1_cmd2", (q1.size() > 2) ? q1[2] : 16'hxxxx, 16'h8100);
        chk("inst1_cmd3", (q1.size() > 3) ? q1[3] : 16'hxxxx, 16'h8200);

        // timeout: third read of the next burst never completes
        drop_at = rdcnt[0] + 3;
        q0.delete();
        pulse_int0(3, 0);
        n = 0;
        while (!tmo0 && n < 300) begin @(negedge clk); n++; end
        chk("tmo_rise", tmo0, 1'b1);
        chk("tmo_lat", 80'(cyc - drop_wrt_cyc), 80'd16);
        chk("tmo_init_done_low", idn0, 1'b0);
        chk("tmo_data_held", data0, sample);
        drop_at = 0;
        n = 0;
        while (!idn0 && n < 300) begin @(negedge clk); n++; end
        chk("reinit_done", idn0, 1'b1);
        chk("reinit_cmd_count", 80'(q0.size()), 80'd7);
        for (int k = 0; k < 4; k++)
            chk($sformatf("reinit_cmd%0d", k), (k + 3 < q0.size()) ? q0[k+3] : 16'hxxxx, exp_init[k]);
        chk("tmo_sticky", tmo0, 1'b1);
        chk("reinit_data_held", data0, sample);

        // asynchronous reset in the middle of a burst
        r0 = rdcnt[0];
        pulse_int0(3, 0);
        n = 0;
        while (rdcnt[0] < r0 + 3 && n < 200) begin @(negedge clk); n++; end
        #2 rst = 1'b1;
        #1;
        chk("arst_data", data0, 80'd0);
        chk("arst_init_done", idn0, 1'b0);
        chk("arst_tmo", tmo0, 1'b0);
        chk("arst_spi_wrt", wrt0, 1'b0);
        chk("arst_spi_cmd", cmd0, 16'h0000);
        chk("arst_vld", vld0, 1'b0);
        repeat (2) @(negedge clk);
        q0.delete();
        rst = 1'b0;
        t0 = cyc;
        n = 0;
        while (!wrt0 && n < 100) begin @(negedge clk); n++; end
        chk("arst_pwrup_cycles", 80'(cyc - t0), 80'd16);
        chk("arst_pwrup_cmd0", cmd0, 16'h0D02);
        n = 0;
        while (!idn0 && n < 200) begin @(negedge clk); n++; end
        chk("arst_reinit_done", idn0, 1'b1);
        chk("arst_init_cmd_count", 80'(q0.size()), 80'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
